axi_wr_arbiter: RTL and testbench
=================================

// Module: axi_wr_arbiter
// PURPOSE
//  NUM_M-to-1 AXI4 write-path arbiter for the shared, ID-less downstream write port.
//  Round-robin on AW. W beats are routed in AW grant order. B responses are routed back by
//  grant order, using FIFOs of master indices in place of AXI IDs.
//  Sits between several upstream write masters and one in-order write slave.
// PARAMETERS
//  NUM_M           2   number of upstream masters (>=2)
//  ADDR_WIDTH      32  address width
//  DATA_WIDTH      64  data width; strobe width = DATA_WIDTH/8
//  MAX_W_INFLIGHT  8   depth of W-route FIFO (granted AWs whose W burst is not yet complete)
//  MAX_B_INFLIGHT  8   depth of B-route FIFO (granted AWs awaiting B)
// PORTS
//  aclk           in   1                 clock
//  aresetn        in   1                 async active-low reset
//  s_axi_awvalid  in   NUM_M             per-master AW valid
//  s_axi_awready  out  NUM_M             per-master AW ready
//  s_axi_awpay    in   NUM_M*AW_PAY_W    per-master {addr,len,size,burst,lock,cache,prot,qos,region}
//  s_axi_wvalid   in   NUM_M             per-master W valid
//  s_axi_wready   out  NUM_M             per-master W ready
//  s_axi_wpay     in   NUM_M*W_PAY_W     per-master {data,strb,last}
//  s_axi_bvalid   out  NUM_M             per-master B valid
//  s_axi_bready   in   NUM_M             per-master B ready
//  s_axi_bresp    out  2                 broadcast bresp (qualified by s_axi_bvalid)
//  m_axi_awvalid  out  1                 downstream AW valid
//  m_axi_awready  in   1                 downstream AW ready
//  m_axi_awpay    out  AW_PAY_W          selected AW payload
//  m_axi_wvalid   out  1                 downstream W valid
//  m_axi_wready   in   1                 downstream W ready
//  m_axi_wpay     out  W_PAY_W           selected W payload
//  m_axi_bvalid   in   1                 downstream B valid
//  m_axi_bready   out  1                 downstream B ready
//  m_axi_bresp    in   2                 downstream bresp
// BEHAVIOUR
//  Reset (async, aresetn=0)
//   - All valid/ready outputs 0; FIFOs empty; lock cleared; priority pointer = master 0.
//   - In-flight transactions are discarded; the downstream slave is reset together with this block.
//  AW arbitration
//   - Enabled only when both FIFOs are !full.
//   - Unlocked: combinational round-robin pick among s_axi_awvalid, starting at the priority pointer.
//   - Zero latency: m_axi_awvalid, m_axi_awpay = winner in the same cycle.
//   - Winner presented but m_axi_awready=0: register lock=1 and sel=winner. Grant and payload then
//     stay fixed until the handshake. Other requests are ignored meanwhile.
//   - s_axi_awready[i] = (sel==i) & m_axi_awready & FIFOs !full.
//   - On handshake: push sel into both FIFOs, clear lock, pointer = (sel+1) mod NUM_M.
//  W routing
//   - Head of W FIFO selects the master.
//   - m_axi_wvalid = s_axi_wvalid[head]; s_axi_wready[head] = m_axi_wready; all other s_axi_wready = 0.
//   - Pop on a handshake with wlast=1. Beat count is not checked; wlast alone ends the burst.
//   - FIFO empty: m_axi_wvalid=0, all s_axi_wready=0. W-before-AW is held off, no bypass.
//   - First beat may transfer the cycle after the AW handshake.
//  B routing
//   - Head of B FIFO selects the master.
//   - s_axi_bvalid[head] = m_axi_bvalid; m_axi_bready = s_axi_bready[head]; pop on handshake.
//   - FIFO empty: m_axi_bready=0, all s_axi_bvalid=0.
//  Full/simultaneous
//   - Push is blocked on full even if a pop occurs in the same cycle.
//   - Push and pop in the same cycle on a non-full FIFO: count unchanged.
//  Ordering
//   - The downstream slave must return B in AW order; this is not checked.
// STRUCTURE
//  Package axi_arb_pkg:
//   - AW_PAY_W = ADDR_WIDTH+29.
//   - W_PAY_W = DATA_WIDTH+DATA_WIDTH/8+1.
//   - SEL_W = $clog2(NUM_M).
//   - Function rr_pick(req, ptr) returning index and found flag.
//  Sub-module: the team's axi_id_killer_fifo, instantiated twice (W-route, B-route) with WIDTH=SEL_W.
// TESTING
//  1. Reset, m_awready=1, both masters AW valid for 2 cycles -> grants M0 then M1, 1 per cycle.
//  2. M0 AW addr=0x100 with m_awready=0 for 3 cycles, M1 AW rises in cycle 2
//     -> m_awpay stays 0x100, s_awready=0 until cycle 4, then M1 is granted.
//  3. M0 AW len=3, then M1 AW len=0; M1 W valid first -> s_wready[1]=0 until M0's 4th beat
//     (wlast) handshakes, then M1's single beat passes.
//  4. Two AWs (M0, M1), m_bvalid with bresp=0 twice, s_bready[0]=0 for 2 cycles
//     -> m_bready=0 for those cycles; B delivered to M0 then M1.
//  5. 8 AWs with no B -> 9th AW m_awvalid=0; one B handshake -> 9th AW issues the next cycle.
//  6. aresetn=0 mid W burst -> all valid/ready outputs 0 immediately; after release, pointer=M0
//     and FIFOs are empty.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared definitions for the write-path arbiter.
// Payload width helpers keep the AW/W packing in one place. rr_pick is the
// round-robin search used on the AW channel. It is sized for up to
// RR_MAX_M masters, and the caller zero-extends its request vector.
package axi_arb_pkg;

    // AW sideband: len(8) size(3) burst(2) lock(1) cache(4) prot(3) qos(4) region(4)
    localparam int AW_SIDE_W = 29;
    localparam int RR_MAX_M  = 16;
    localparam int RR_IDX_W  = 4;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic int aw_pay_w(input int addr_w);
        return addr_w + AW_SIDE_W;
    endfunction

    function automatic int w_pay_w(input int data_w);
        return data_w + data_w / 8 + 1;
    endfunction

    function automatic int sel_w(input int num_m);
        return (num_m > 1) ? $clog2(num_m) : 1;
    endfunction

    // Search starts at ptr and wraps modulo num_m. The first requester found wins.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_M-1:0] req,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int                  num_m);
        rr_pick_t res;
        int       idx;
        res = '0;
        for (int k = 0; k < RR_MAX_M; k++) begin
            if (k < num_m) begin
                idx = int'(ptr) + k;
                if (idx >= num_m) idx = idx - num_m;
                if (!res.found && req[idx[RR_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = idx[RR_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_id_killer_fifo.sv
// Small FIFO that carries master indices.
// A push is refused while the FIFO is full, even if a pop happens in the same
// cycle. A pop is ignored while the FIFO is empty.
// Ports: aclk/aresetn, push/push_data, pop, head (current front entry),
//        empty, full.
module axi_id_killer_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is read only after it has been written.
    always_ff @(posedge aclk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// NUM_M-to-1 AXI4 write-path arbiter for an in-order, ID-less write slave.
// AW uses round-robin arbitration. Once a grant has been presented, it is
// locked until the handshake. W bursts and B responses are steered by two
// FIFOs of master indices, which are filled in AW grant order.
// Ports:
//   s_axi_aw*  per-master AW (valid/ready, packed payload)
//   s_axi_w*   per-master W  (valid/ready, packed {data,strb,last})
//   s_axi_b*   per-master B valid/ready, with a broadcast bresp
//   m_axi_*    single downstream AW/W/B port
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int NUM_M          = 2,
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 64,
    parameter  int MAX_W_INFLIGHT = 8,
    parameter  int MAX_B_INFLIGHT = 8,
    localparam int AW_PAY_W       = aw_pay_w(ADDR_WIDTH),
    localparam int W_PAY_W        = w_pay_w(DATA_WIDTH)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_M-1:0]          s_axi_awvalid,
    output logic [NUM_M-1:0]          s_axi_awready,
    input  logic [NUM_M*AW_PAY_W-1:0] s_axi_awpay,
    input  logic [NUM_M-1:0]          s_axi_wvalid,
    output logic [NUM_M-1:0]          s_axi_wready,
    input  logic [NUM_M*W_PAY_W-1:0]  s_axi_wpay,
    output logic [NUM_M-1:0]          s_axi_bvalid,
    input  logic [NUM_M-1:0]          s_axi_bready,
    output logic [1:0]                s_axi_bresp,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [AW_PAY_W-1:0]       m_axi_awpay,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    output logic [W_PAY_W-1:0]        m_axi_wpay,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic [1:0]                m_axi_bresp
);
    localparam int SEL_W = sel_w(NUM_M);

    logic [SEL_W-1:0]    ptr_q, ptr_d, sel_q, sel_d;
    logic                lock_q, lock_d;
    logic [SEL_W-1:0]    rr_sel, aw_sel, w_head, b_head;
    logic [RR_MAX_M-1:0] req_ext;
    rr_pick_t            rr;
    logic                aw_any, aw_en, aw_hs;
    logic                w_empty, w_full, w_pop;
    logic                b_empty, b_full, b_pop;

    // ---------------- AW arbitration ----------------
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_M-1:0]   = s_axi_awvalid;
        rr                   = rr_pick(req_ext, RR_IDX_W'(ptr_q), NUM_M);
        rr_sel               = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (rr.idx == RR_IDX_W'(i)) rr_sel = SEL_W'(i);
        end
    end

    // A locked grant keeps the same master and payload until the handshake.
    assign aw_sel = lock_q ? sel_q : rr_sel;
    assign aw_any = lock_q | rr.found;
    // aresetn gating keeps AW quiet while held in reset, even if a master still drives valid.
    assign aw_en  = aresetn & ~w_full & ~b_full;
    assign m_axi_awvalid = aw_en & aw_any;
    assign aw_hs  = m_axi_awvalid & m_axi_awready;

    always_comb begin
        s_axi_awready = '0;
        m_axi_awpay   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (aw_sel == SEL_W'(i)) begin
                m_axi_awpay      = s_axi_awpay[i*AW_PAY_W +: AW_PAY_W];
                s_axi_awready[i] = aw_en & aw_any & m_axi_awready;
            end
        end
    end

    always_comb begin
        lock_d = lock_q;
        sel_d  = sel_q;
        ptr_d  = ptr_q;
        if (aw_hs) begin
            lock_d = 1'b0;
            ptr_d  = (aw_sel == SEL_W'(NUM_M - 1)) ? '0 : aw_sel + 1'b1;
        end else if (m_axi_awvalid) begin
            lock_d = 1'b1;
            sel_d  = aw_sel;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lock_q <= 1'b0;
            sel_q  <= '0;
            ptr_q  <= '0;
        end else begin
            lock_q <= lock_d;
            sel_q  <= sel_d;
            ptr_q  <= ptr_d;
        end
    end

    // ---------------- W routing ----------------
    always_comb begin
        s_axi_wready = '0;
        m_axi_wvalid = 1'b0;
        m_axi_wpay   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (!w_empty && w_head == SEL_W'(i)) begin
                m_axi_wvalid    = s_axi_wvalid[i];
                m_axi_wpay      = s_axi_wpay[i*W_PAY_W +: W_PAY_W];
                s_axi_wready[i] = m_axi_wready;
            end
        end
    end

    // wlast (bit 0 of the W payload) alone ends the burst.
    assign w_pop = m_axi_wvalid & m_axi_wready & m_axi_wpay[0];

    // ---------------- B routing ----------------
    always_comb begin
        s_axi_bvalid = '0;
        m_axi_bready = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (!b_empty && b_head == SEL_W'(i)) begin
                s_axi_bvalid[i] = m_axi_bvalid;
                m_axi_bready    = s_axi_bready[i];
            end
        end
    end

    assign s_axi_bresp = m_axi_bresp;
    assign b_pop       = m_axi_bvalid & m_axi_bready;

    axi_id_killer_fifo #(.WIDTH(SEL_W), .DEPTH(MAX_W_INFLIGHT)) u_w_route (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (aw_hs),
        .push_data (aw_sel),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full)
    );

    axi_id_killer_fifo #(.WIDTH(SEL_W), .DEPTH(MAX_B_INFLIGHT)) u_b_route (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (aw_hs),
        .push_data (aw_sel),
        .pop       (b_pop),
        .head      (b_head),
        .empty     (b_empty),
        .full      (b_full)
    );

endmodule

// File: tb/tb_axi_wr_arbiter.sv
module tb_axi_wr_arbiter;
    import axi_arb_pkg::*;

    localparam int NUM_M = 2;
    localparam int AW_W  = aw_pay_w(32);
    localparam int W_W   = w_pay_w(64);

    logic                   aclk = 1'b0;
    logic                   aresetn;
    logic [NUM_M-1:0]       s_axi_awvalid, s_axi_awready;
    logic [NUM_M*AW_W-1:0]  s_axi_awpay;
    logic [NUM_M-1:0]       s_axi_wvalid, s_axi_wready;
    logic [NUM_M*W_W-1:0]   s_axi_wpay;
    logic [NUM_M-1:0]       s_axi_bvalid, s_axi_bready;
    logic [1:0]             s_axi_bresp;
    logic                   m_axi_awvalid, m_axi_awready;
    logic [AW_W-1:0]        m_axi_awpay;
    logic                   m_axi_wvalid, m_axi_wready;
    logic [W_W-1:0]         m_axi_wpay;
    logic                   m_axi_bvalid, m_axi_bready;
    logic [1:0]             m_axi_bresp;

    axi_wr_arbiter #(.NUM_M(NUM_M), .ADDR_WIDTH(32), .DATA_WIDTH(64),
                     .MAX_W_INFLIGHT(8), .MAX_B_INFLIGHT(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awpay(s_axi_awpay),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wpay(s_axi_wpay),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awpay(m_axi_awpay),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wpay(m_axi_wpay),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [W_W-1:0] pay; int m; } exp_t;
    typedef struct { int m; logic [1:0] resp; } exp_b_t;
    exp_t   aw_q[$];
    exp_t   w_q[$];
    exp_b_t b_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [AW_W-1:0] mk_aw(input logic [31:0] addr, input logic [7:0] len);
        return {addr, len, 3'd3, 2'b01, 1'b0, 4'h3, 3'd0, 4'h0, 4'h0};
    endfunction

    function automatic logic [W_W-1:0] mk_w(input logic [63:0] data, input logic last);
        return {data, 8'hFF, last};
    endfunction

    // Monitor: pops the expected entry on every handshake the DUT presents.
    always @(negedge aclk) begin
        exp_t   e;
        exp_b_t eb;
        if (aresetn) begin
            if (m_axi_awvalid && m_axi_awready) begin
                if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
                else begin
                    e = aw_q.pop_front();
                    chk("aw_pay", m_axi_awpay, e.pay);
                    chk("aw_grant", s_axi_awready, 128'(1) << e.m);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (w_q.size() == 0) chk("w_unexpected", 1, 0);
                else begin
                    e = w_q.pop_front();
                    chk("w_pay", m_axi_wpay, e.pay);
                    chk("w_route", s_axi_wready, 128'(1) << e.m);
                end
            end
            for (int i = 0; i < NUM_M; i++) begin
                if (s_axi_bvalid[i] && s_axi_bready[i]) begin
                    if (b_q.size() == 0) chk("b_unexpected", 1, 0);
                    else begin
                        eb = b_q.pop_front();
                        chk("b_master", i, eb.m);
                        chk("b_resp", s_axi_bresp, eb.resp);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic aw_req(input int m, input logic [31:0] addr, input logic [7:0] len);
        logic ok;
        ok = 1'b0;
        s_axi_awvalid[m] = 1'b1;
        s_axi_awpay[m*AW_W +: AW_W] = mk_aw(addr, len);
        aw_q.push_back('{pay: W_W'(mk_aw(addr, len)), m: m});
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (s_axi_awready[m]) ok = 1'b1;
            tick();
        end
        chk("aw_wait", ok, 1);
        s_axi_awvalid[m] = 1'b0;
    endtask

    task automatic w_beat(input int m, input logic [63:0] data, input logic last);
        logic ok;
        ok = 1'b0;
        s_axi_wvalid[m] = 1'b1;
        s_axi_wpay[m*W_W +: W_W] = mk_w(data, last);
        w_q.push_back('{pay: mk_w(data, last), m: m});
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (s_axi_wready[m]) ok = 1'b1;
            tick();
        end
        chk("w_wait", ok, 1);
        s_axi_wvalid[m] = 1'b0;
    endtask

    task automatic b_resp(input logic [1:0] resp, input int m);
        logic ok;
        ok = 1'b0;
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = resp;
        b_q.push_back('{m: m, resp: resp});
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (m_axi_bready) ok = 1'b1;
            tick();
        end
        chk("b_wait", ok, 1);
        m_axi_bvalid = 1'b0;
    endtask

    task automatic chk_all_quiet(input string tag);
        chk({tag, "_m_awvalid"}, m_axi_awvalid, 0);
        chk({tag, "_s_awready"}, s_axi_awready, 0);
        chk({tag, "_m_wvalid"},  m_axi_wvalid, 0);
        chk({tag, "_s_wready"},  s_axi_wready, 0);
        chk({tag, "_m_bready"},  m_axi_bready, 0);
        chk({tag, "_s_bvalid"},  s_axi_bvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn       = 1'b0;
        s_axi_awvalid = '0;
        s_axi_awpay   = '0;
        s_axi_wvalid  = '0;
        s_axi_wpay    = '0;
        s_axi_bready  = '1;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        repeat (3) @(posedge aclk);
        #1;
        chk_all_quiet("rst");
        aresetn = 1'b1;
        tick();

        // 1: both masters request for two cycles -> M0 then M1
        s_axi_awvalid = 2'b11;
        s_axi_awpay   = {mk_aw(32'h2000, 8'd0), mk_aw(32'h1000, 8'd0)};
        aw_q.push_back('{pay: W_W'(mk_aw(32'h1000, 8'd0)), m: 0});
        aw_q.push_back('{pay: W_W'(mk_aw(32'h2000, 8'd0)), m: 1});
        #1 chk("t1_grant0", s_axi_awready, 2'b01);
        tick();
        #1 chk("t1_grant1", s_axi_awready, 2'b10);
        tick();
        s_axi_awvalid = 2'b00;
        #1 chk("t1_idle", m_axi_awvalid, 0);
        s_axi_wvalid = 2'b11;
        s_axi_wpay   = {mk_w(64'hA1, 1'b1), mk_w(64'hA0, 1'b1)};
        w_q.push_back('{pay: mk_w(64'hA0, 1'b1), m: 0});
        w_q.push_back('{pay: mk_w(64'hA1, 1'b1), m: 1});
        #1 chk("t1_wready0", s_axi_wready, 2'b01);
        tick();
        #1 chk("t1_wready1", s_axi_wready, 2'b10);
        tick();
        s_axi_wvalid = 2'b00;
        #1 chk("t1_w_empty_valid", m_axi_wvalid, 0);
        chk("t1_w_empty_ready", s_axi_wready, 2'b00);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b00;
        b_q.push_back('{m: 0, resp: 2'b00});
        #1 chk("t1_bvalid0", s_axi_bvalid, 2'b01);
        tick();
        m_axi_bresp = 2'b10;
        b_q.push_back('{m: 1, resp: 2'b10});
        #1 chk("t1_bvalid1", s_axi_bvalid, 2'b10);
        tick();
        m_axi_bvalid = 1'b0;
        #1 chk("t1_b_empty_ready", m_axi_bready, 0);

        // 2: M0 held by m_awready=0, M1 rises meanwhile
        tick();
        m_axi_awready = 1'b0;
        s_axi_awvalid = 2'b01;
        s_axi_awpay[0 +: AW_W] = mk_aw(32'h100, 8'd0);
        aw_q.push_back('{pay: W_W'(mk_aw(32'h100, 8'd0)), m: 0});
        #1 chk("t2_c1_pay", m_axi_awpay, mk_aw(32'h100, 8'd0));
        chk("t2_c1_ready", s_axi_awready, 2'b00);
        tick();
        s_axi_awvalid = 2'b11;
        s_axi_awpay[AW_W +: AW_W] = mk_aw(32'h200, 8'd0);
        #1 chk("t2_c2_pay", m_axi_awpay, mk_aw(32'h100, 8'd0));
        chk("t2_c2_ready", s_axi_awready, 2'b00);
        tick();
        #1 chk("t2_c3_pay", m_axi_awpay, mk_aw(32'h100, 8'd0));
        chk("t2_c3_valid", m_axi_awvalid, 1);
        tick();
        m_axi_awready = 1'b1;
        #1 chk("t2_c4_ready", s_axi_awready, 2'b01);
        tick();
        s_axi_awvalid = 2'b10;
        aw_q.push_back('{pay: W_W'(mk_aw(32'h200, 8'd0)), m: 1});
        #1 chk("t2_c5_ready", s_axi_awready, 2'b10);
        tick();
        s_axi_awvalid = 2'b00;
        w_beat(0, 64'hB0, 1'b1);
        w_beat(1, 64'hB1, 1'b1);
        b_resp(2'b00, 0);
        b_resp(2'b01, 1);

        // 3: M1 W waits behind M0's 4-beat burst
        aw_req(0, 32'h400, 8'd3);
        aw_req(1, 32'h500, 8'd0);
        s_axi_wvalid[1] = 1'b1;
        s_axi_wpay[W_W +: W_W] = mk_w(64'hD1, 1'b1);
        #1 chk("t3_m1_blocked", s_axi_wready[1], 0);
        chk("t3_no_wvalid", m_axi_wvalid, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            s_axi_wvalid[0] = 1'b1;
            s_axi_wpay[0 +: W_W] = mk_w(64'hC0 + 64'(k), k == 3);
            w_q.push_back('{pay: mk_w(64'hC0 + 64'(k), k == 3), m: 0});
            #1 chk("t3_beat_route", s_axi_wready, 2'b01);
            tick();
        end
        s_axi_wvalid[0] = 1'b0;
        w_q.push_back('{pay: mk_w(64'hD1, 1'b1), m: 1});
        #1 chk("t3_m1_go", s_axi_wready, 2'b10);
        tick();
        s_axi_wvalid = 2'b00;
        b_resp(2'b00, 0);
        b_resp(2'b01, 1);

        // 4: B to M0 stalled by s_bready[0]=0
        aw_req(0, 32'h600, 8'd0);
        aw_req(1, 32'h700, 8'd0);
        w_beat(0, 64'hE0, 1'b1);
        w_beat(1, 64'hE1, 1'b1);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b00;
        s_axi_bready = 2'b10;
        b_q.push_back('{m: 0, resp: 2'b00});
        #1 chk("t4_stall1", m_axi_bready, 0);
        chk("t4_bvalid0", s_axi_bvalid, 2'b01);
        tick();
        #1 chk("t4_stall2", m_axi_bready, 0);
        tick();
        s_axi_bready = 2'b11;
        #1 chk("t4_release", m_axi_bready, 1);
        tick();
        b_q.push_back('{m: 1, resp: 2'b00});
        #1 chk("t4_bvalid1", s_axi_bvalid, 2'b10);
        tick();
        m_axi_bvalid = 1'b0;

        // 5: B-route FIFO full blocks the 9th AW
        for (int k = 0; k < 8; k++) aw_req(k % 2, 32'h3000 + 32'(k * 16), 8'd0);
        for (int k = 0; k < 8; k++) w_beat(k % 2, 64'hF0 + 64'(k), 1'b1);
        s_axi_awvalid[0] = 1'b1;
        s_axi_awpay[0 +: AW_W] = mk_aw(32'h9000, 8'd1);
        aw_q.push_back('{pay: W_W'(mk_aw(32'h9000, 8'd1)), m: 0});
        #1 chk("t5_full_valid", m_axi_awvalid, 0);
        chk("t5_full_ready", s_axi_awready, 2'b00);
        tick();
        #1 chk("t5_full_valid2", m_axi_awvalid, 0);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b00;
        b_q.push_back('{m: 0, resp: 2'b00});
        #1 chk("t5_b_ready", m_axi_bready, 1);
        tick();
        m_axi_bvalid = 1'b0;
        #1 chk("t5_aw_resume", m_axi_awvalid, 1);
        chk("t5_aw_ready", s_axi_awready, 2'b01);
        tick();
        s_axi_awvalid = 2'b00;

        // 6: reset in the middle of the 9th AW's W burst
        s_axi_wvalid[0] = 1'b1;
        s_axi_wpay[0 +: W_W] = mk_w(64'h55, 1'b0);
        w_q.push_back('{pay: mk_w(64'h55, 1'b0), m: 0});
        #1 chk("t6_beat0", s_axi_wready, 2'b01);
        tick();
        aresetn       = 1'b0;
        s_axi_awvalid = 2'b11;
        s_axi_wvalid  = 2'b11;
        m_axi_bvalid  = 1'b1;
        #1 chk_all_quiet("t6_rst");
        aw_q.delete();
        w_q.delete();
        b_q.delete();
        tick();
        tick();
        s_axi_awvalid = 2'b00;
        s_axi_wvalid  = 2'b00;
        m_axi_bvalid  = 1'b0;
        aresetn       = 1'b1;
        tick();
        s_axi_awvalid = 2'b11;
        s_axi_awpay   = {mk_aw(32'hB000, 8'd0), mk_aw(32'hA000, 8'd0)};
        s_axi_wvalid  = 2'b11;
        m_axi_bvalid  = 1'b1;
        aw_q.push_back('{pay: W_W'(mk_aw(32'hA000, 8'd0)), m: 0});
        #1 chk("t6_ptr_m0", s_axi_awready, 2'b01);
        chk("t6_w_empty", m_axi_wvalid, 0);
        chk("t6_w_ready", s_axi_wready, 2'b00);
        chk("t6_b_empty", m_axi_bready, 0);
        chk("t6_b_valid", s_axi_bvalid, 2'b00);
        tick();
        s_axi_awvalid = 2'b00;
        s_axi_wvalid  = 2'b00;
        m_axi_bvalid  = 1'b0;
        w_beat(0, 64'h77, 1'b1);
        b_resp(2'b01, 0);
        tick();
        chk("end_aw_q", aw_q.size(), 0);
        chk("end_w_q", w_q.size(), 0);
        chk("end_b_q", b_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
